// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : Circular byte FIFO in front of a UART transmitter. Bytes are
//               written by the bus with a single-cycle strobe. They are then
//               launched one at a time with the transmitter's tx_wr / tx_active
//               / tx_done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              busy,
  output logic              tx_wr,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done
);

  localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  // Storage and pointers
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic              r_busy;
  logic              r_tx_wr;
  logic [7:0]        r_tx_byte;
  state_t            r_state;

  // Per-cycle decisions, all taken against the registered flags
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_idle_next;
  logic [ADDR_W:0]   w_count_next;
  logic              w_busy_next;

  // A write is accepted only while not full; a write while full is dropped
  // even when a pop frees a slot in the same cycle.
  assign w_push = wr_en && !r_full;
  assign w_drop = wr_en &&  r_full;

  // Launch only from IDLE with data present and the transmitter quiet. The
  // tx_done check matters after a reset that lands mid-frame.
  assign w_pop  = (r_state == IDLE) && !r_empty && !tx_active && !tx_done;

  // Next occupancy: a simultaneous push and pop leaves it unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_cnt_one;
      2'b01:   w_count_next = r_count - c_cnt_one;
      default: w_count_next = r_count;
    endcase
  end

  // Whether the launcher will sit in IDLE after this edge (feeds registered busy)
  always_comb begin
    w_idle_next = 1'b0;
    case (r_state)
      IDLE:      w_idle_next = !w_pop;
      WAIT_IDLE: w_idle_next = !tx_done && !tx_active;
      default:   w_idle_next = 1'b0;
    endcase
  end

  assign w_busy_next = (w_count_next != '0) || !w_idle_next;

  // FIFO storage; the contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the status flags derived from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_depth);
      r_empty <= (w_count_next == '0);
      r_busy  <= w_busy_next;
    end
  end

  // Sticky overflow flag; a dropped write beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Launch state machine: issue one byte, then follow the transmitter through
  // its frame and the two-cycle tx_done before allowing the next launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tx_wr   <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_tx_wr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_byte <= r_mem[r_rd_ptr];
            r_tx_wr   <= 1'b1;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_active || tx_done) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            r_state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (!tx_done && !tx_active) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign busy     = r_busy;
  assign tx_wr    = r_tx_wr;
  assign tx_byte  = r_tx_byte;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_feeder
// Description : Scoreboard bench for uart_tx_feeder with a simple transmitter
//               model. Accepted bytes are queued as expected launches, and a
//               monitor pops and checks them on every tx_wr pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ovf_clr;
  logic              busy;
  logic              tx_wr;
  logic [7:0]        tx_byte;
  logic              tx_active;
  logic              tx_done;

  logic              m_active;
  logic              hold_active;
  int                frame_len;

  logic [7:0]        exp_q [$];
  int                n_cmp;
  int                n_bad;
  int                n_launch;

  assign tx_active = m_active | hold_active;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .busy      (busy),
    .tx_wr     (tx_wr),
    .tx_byte   (tx_byte),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for one cycle; queue it as an expected launch if it
  // should be accepted. The strobe is left high for back-to-back calls.
  task automatic write_byte(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    tick();
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_drained(input string name, input int budget);
    int t;
    t = 0;
    wr_en = 1'b0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && t < budget) begin
      tick();
      t++;
    end
    chk(name, 32'(t < budget), 32'd1);
  endtask

  // Transmitter model: frame of frame_len cycles, then a two-cycle tx_done
  initial begin
    m_active = 1'b0;
    tx_done  = 1'b0;
    forever begin
      tick();
      if (tx_wr === 1'b1) begin
        m_active = 1'b1;
        repeat (frame_len) tick();
        m_active = 1'b0;
        tx_done  = 1'b1;
        repeat (2) tick();
        tx_done  = 1'b0;
      end
    end
  end

  // Monitor: every launch must be a single-cycle pulse, made while the
  // transmitter was quiet, carrying the next expected byte.
  initial begin
    logic       prev_active;
    logic       prev_done;
    logic       prev_wr;
    logic [7:0] exp_b;
    prev_active = 1'b0;
    prev_done   = 1'b0;
    prev_wr     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_wr === 1'b1) begin
        n_launch++;
        chk("launch_guard", {30'd0, prev_active, prev_done}, 32'd0);
        chk("tx_wr_single", 32'(prev_wr), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_launch", 32'(tx_byte), 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          chk("tx_byte", 32'(tx_byte), 32'(exp_b));
        end
      end
      prev_active = tx_active;
      prev_done   = tx_done;
      prev_wr     = tx_wr;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] hello [5];
    int         launches;
    int         t;
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    n_cmp       = 0;
    n_bad       = 0;
    n_launch    = 0;
    rst_n       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    ovf_clr     = 1'b0;
    hold_active = 1'b0;
    frame_len   = 4;

    // Reset state
    repeat (3) tick();
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_wr",    32'(tx_wr),    32'd0);
    chk("rst_tx_byte",  32'(tx_byte),  32'h00);
    rst_n = 1'b1;
    tick();

    // Single byte: one-cycle latency to launch, pulse lasts one cycle
    write_byte(8'h41, 1'b1);
    wr_en = 1'b0;
    chk("single_count_after_wr", 32'(count), 32'd1);
    tick();
    chk("single_tx_wr",   32'(tx_wr),   32'd1);
    chk("single_tx_byte", 32'(tx_byte), 32'h41);
    chk("single_empty",   32'(empty),   32'd1);
    chk("single_busy",    32'(busy),    32'd1);
    tick();
    chk("single_tx_wr_low", 32'(tx_wr),   32'd0);
    chk("single_byte_hold", 32'(tx_byte), 32'h41);
    wait_drained("single_drain", 200);
    chk("single_busy_end", 32'(busy), 32'd0);

    // HELLO burst: first byte launches immediately so occupancy peaks at 4
    launches = n_launch;
    for (int i = 0; i < 5; i++) write_byte(hello[i], 1'b1);
    wr_en = 1'b0;
    chk("hello_count_peak", 32'(count), 32'd4);
    wait_drained("hello_drain", 1000);
    chk("hello_launches", 32'(n_launch - launches), 32'd5);
    chk("hello_overflow", 32'(overflow), 32'd0);

    // Fill with the transmitter held busy: 16 accepted, 17th dropped
    hold_active = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h80 + i), 1'b1);
    wr_en = 1'b0;
    chk("fill_full",     32'(full),     32'd1);
    chk("fill_count",    32'(count),    32'd16);
    chk("fill_overflow", 32'(overflow), 32'd0);
    write_byte(8'hDD, 1'b0);
    wr_en = 1'b0;
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_count",    32'(count),    32'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    // Drop and clear together: set wins
    ovf_clr = 1'b1;
    write_byte(8'hDE, 1'b0);
    ovf_clr = 1'b0;
    wr_en   = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    // Write while full with a same-cycle pop: still dropped
    hold_active = 1'b0;
    write_byte(8'hEE, 1'b0);
    wr_en = 1'b0;
    chk("full_pop_drop_overflow", 32'(overflow), 32'd1);
    chk("full_pop_drop_count",    32'(count),    32'd15);
    chk("full_pop_drop_full",     32'(full),     32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    frame_len = 20;
    wait_drained("fill_drain", 1500);
    chk("fill_count_end", 32'(count), 32'd0);

    // Simultaneous write and pop at count=3
    hold_active = 1'b1;
    for (int i = 0; i < 3; i++) write_byte(8'(8'hA1 + i), 1'b1);
    wr_en = 1'b0;
    chk("sim_count_pre", 32'(count), 32'd3);
    hold_active = 1'b0;
    write_byte(8'hA4, 1'b1);
    wr_en = 1'b0;
    chk("sim_count_same", 32'(count), 32'd3);
    wait_drained("sim_drain", 500);

    // Wrap-around: 40 writes interleaved with drains
    for (int i = 0; i < 40; i++) begin
      write_byte(8'(i * 7 + 3), 1'b1);
      idle((i % 2 == 0) ? 5 : 45);
    end
    wait_drained("wrap_drain", 2000);
    chk("wrap_count_end", 32'(count),    32'd0);
    chk("wrap_overflow",  32'(overflow), 32'd0);

    // Reset mid-frame with 4 bytes queued
    for (int i = 0; i < 5; i++) write_byte(8'(8'hC0 + i), 1'b1);
    wr_en = 1'b0;
    chk("midrst_count_pre", 32'(count), 32'd4);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_tx_wr", 32'(tx_wr), 32'd0);
    launches = n_launch;
    write_byte(8'h5A, 1'b1);
    wr_en = 1'b0;
    t = 0;
    while (n_launch == launches && t < 100) begin
      tick();
      t++;
    end
    chk("midrst_relaunch", 32'(n_launch - launches), 32'd1);
    wait_drained("midrst_drain", 500);
    chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
